// File: rtl/led_pwm_scheduler.sv
// Two-bank LED "breathing" scheduler: a round-robin arbiter hands one shared PWM
// engine to the red or green bank, which ramps its duty up and back down.
module led_pwm_scheduler #(
  parameter int PWM_PERIOD      = 1000,
  parameter int DUTY_STEP       = 100,
  parameter int FRAMES_PER_STEP = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_red,
  input  logic       req_green,
  output logic [9:0] led_red,
  output logic [7:0] led_green,
  output logic       grant_red,
  output logic       grant_green,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RAMP_UP   = 2'd1;
  localparam logic [1:0] RAMP_DOWN = 2'd2;

  localparam logic [31:0] P = 32'(PWM_PERIOD);
  localparam logic [31:0] S = 32'(DUTY_STEP);
  localparam logic [31:0] F = 32'(FRAMES_PER_STEP);

  generate
    if (DUTY_STEP <= 0 || FRAMES_PER_STEP <= 0 || PWM_PERIOD <= 0 ||
        (PWM_PERIOD % DUTY_STEP) != 0) begin : g_bad_params
      $error("led_pwm_scheduler: PWM_PERIOD must be a multiple of DUTY_STEP > 0, FRAMES_PER_STEP > 0");
    end
  endgenerate

  // Request/grant: a request is a level sampled only while idle; once granted,
  // the bank owns the engine until done, regardless of its request.
  logic [1:0]  state_q, state_d;
  logic        grant_red_q, grant_red_d;
  logic        grant_green_q, grant_green_d;
  logic        last_red_q, last_red_d;
  logic        done_q, done_d;
  logic [31:0] duty_q, duty_d;
  logic [31:0] pwm_cnt_q, pwm_cnt_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic        led_red_q, led_green_q;
  logic        frame_end, step_end, pick_red, pwm_on;

  assign frame_end = (pwm_cnt_q == P - 32'd1);
  assign step_end  = frame_end && (frame_cnt_q == F - 32'd1);
  assign pick_red  = req_red && (!req_green || !last_red_q);
  assign pwm_on    = (pwm_cnt_q < duty_q);

  always_comb begin
    state_d       = state_q;
    grant_red_d   = grant_red_q;
    grant_green_d = grant_green_q;
    last_red_d    = last_red_q;
    done_d        = 1'b0;
    duty_d        = duty_q;
    pwm_cnt_d     = pwm_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_red || req_green) begin
          state_d       = RAMP_UP;
          grant_red_d   = pick_red;
          grant_green_d = !pick_red;
          last_red_d    = pick_red;
          duty_d        = '0;
          pwm_cnt_d     = '0;
          frame_cnt_d   = '0;
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        pwm_cnt_d = frame_end ? 32'd0 : pwm_cnt_q + 32'd1;
        if (frame_end) frame_cnt_d = step_end ? 32'd0 : frame_cnt_q + 32'd1;
        if (step_end) begin
          if (state_q == RAMP_UP) begin
            if (duty_q == P) begin
              state_d = RAMP_DOWN;
              duty_d  = P - S;
            end else begin
              duty_d = duty_q + S;
            end
          end else if (duty_q == 32'd0) begin
            // Grant drops on the same edge that raises done.
            state_d       = IDLE;
            done_d        = 1'b1;
            grant_red_d   = 1'b0;
            grant_green_d = 1'b0;
          end else begin
            duty_d = duty_q - S;
          end
        end
      end
      default: begin
        state_d       = IDLE;
        grant_red_d   = 1'b0;
        grant_green_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_red_q   <= 1'b0;
      grant_green_q <= 1'b0;
      last_red_q    <= 1'b0;
      done_q        <= 1'b0;
      duty_q        <= '0;
      pwm_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      led_red_q     <= 1'b0;
      led_green_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_red_q   <= grant_red_d;
      grant_green_q <= grant_green_d;
      last_red_q    <= last_red_d;
      done_q        <= done_d;
      duty_q        <= duty_d;
      pwm_cnt_q     <= pwm_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      led_red_q     <= grant_red_q && pwm_on;
      led_green_q   <= grant_green_q && pwm_on;
    end
  end

  assign led_red     = {10{led_red_q}};
  assign led_green   = {8{led_green_q}};
  assign grant_red   = grant_red_q;
  assign grant_green = grant_green_q;
  assign busy        = grant_red_q | grant_green_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_led_pwm_scheduler.sv
// Bench for led_pwm_scheduler at P=10, S=5, FRAMES_PER_STEP=2: drivers queue the
// expected breathing cycle, a negedge monitor checks each one as it completes.
module tb_led_pwm_scheduler;

  localparam int P = 10;
  localparam int S = 5;
  localparam int F = 2;
  localparam int BUSY_LEN = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_red = 1'b0;
  logic       req_green = 1'b0;
  logic [9:0] led_red;
  logic [7:0] led_green;
  logic       grant_red, grant_green, busy, done;
  logic [1:0] dbg_state;

  int tests = 0;
  int failures = 0;

  // Entry: {aborted, bank_is_red, busy_len[7:0], gap[7:0]}; gap 0 = not checked.
  logic [17:0] exp_q[$];
  int exp_hi[10] = '{0, 0, 5, 5, 10, 10, 5, 5, 0, 0};

  led_pwm_scheduler #(.PWM_PERIOD(P), .DUTY_STEP(S), .FRAMES_PER_STEP(F)) dut (
    .clk(clk), .rst(rst), .req_red(req_red), .req_green(req_green),
    .led_red(led_red), .led_green(led_green), .grant_red(grant_red),
    .grant_green(grant_green), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // Monitor and scoreboard
  int   cyc = 0;
  int   last_done_cyc = -1000;
  logic active = 1'b0;
  logic mon_red = 1'b0;
  int   n, len, gap;
  int   hi[10];

  always @(negedge clk) begin
    logic [17:0] e;
    logic        own_led, own_ok, other_zero;
    cyc++;
    tests++;
    if ((grant_red && grant_green) || (busy != (grant_red | grant_green))) begin
      failures++;
      $display("FAIL grant_excl: grant_red=%0b grant_green=%0b busy=%0b, required one-hot grant and busy=OR",
               grant_red, grant_green, busy);
    end
    if (rst) begin
      tests++;
      if (led_red != 0 || led_green != 0 || grant_red || grant_green || busy || done) begin
        failures++;
        $display("FAIL rst_outputs: led_r=%h led_g=%h gr=%0b gg=%0b busy=%0b done=%0b, required all 0",
                 led_red, led_green, grant_red, grant_green, busy, done);
      end
      if (active) begin
        active = 1'b0;
        tests++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL abort_unexpected: aborted cycle with empty queue, required an expected entry");
        end else begin
          e = exp_q.pop_front();
          if (!e[17] || e[16] != mon_red || e[15:8] != 8'(len)) begin
            failures++;
            $display("FAIL abort_check: aborted=1 red=%0b len=%0d, required aborted=%0b red=%0b len=%0d",
                     mon_red, len, e[17], e[16], e[15:8]);
          end
        end
      end
    end else begin
      if (!active && busy) begin
        active  = 1'b1;
        mon_red = grant_red;
        n       = 0;
        len     = 1;
        gap     = cyc - last_done_cyc;
        for (int k = 0; k < 10; k++) hi[k] = 0;
      end else if (active) begin
        n++;
        if (busy) len++;
        own_led    = mon_red ? led_red[0] : led_green[0];
        own_ok     = mon_red ? (led_red == '0 || led_red == '1) : (led_green == '0 || led_green == '1);
        other_zero = mon_red ? (led_green == '0) : (led_red == '0);
        tests++;
        if (!own_ok || !other_zero) begin
          failures++;
          $display("FAIL led_banks: led_r=%h led_g=%h red_granted=%0b, required uniform own bank and zero other bank",
                   led_red, led_green, mon_red);
        end
        if (n >= 1 && (n - 1) / P < 10 && own_led) hi[(n - 1) / P]++;
      end
      if (done) begin
        tests++;
        if (!active || exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_done: done=1 active=%0b queued=%0d, required a pending breathing cycle",
                   active, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          if (e[17] || e[16] != mon_red || e[15:8] != 8'(len)) begin
            failures++;
            $display("FAIL cycle_check: red=%0b len=%0d, required aborted=%0b red=%0b len=%0d",
                     mon_red, len, e[17], e[16], e[15:8]);
          end
          if (e[7:0] != 8'd0) begin
            tests++;
            if (gap != int'(e[7:0])) begin
              failures++;
              $display("FAIL done_gap: gap=%0d, required %0d", gap, e[7:0]);
            end
          end
          for (int k = 0; k < 10; k++) begin
            tests++;
            if (hi[k] != exp_hi[k]) begin
              failures++;
              $display("FAIL frame_hi[%0d]: high=%0d, required %0d", k, hi[k], exp_hi[k]);
            end
          end
        end
        active        = 1'b0;
        last_done_cyc = cyc;
      end
    end
  end

  // Driver tasks
  task automatic check_bit(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0b, required %0b", name, act, req);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      tests++;
      failures++;
      $display("FAIL %s_timeout: no done in 300 cycles, required done", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (led_red != 0 || led_green != 0 || grant_red || grant_green || busy || done || dbg_state != 2'd0) begin
      failures++;
      $display("FAIL reset_state: outputs not zero or state=%0d, required all 0 and IDLE", dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single red request, one cycle wide
    exp_q.push_back({1'b0, 1'b1, 8'd100, 8'd0});
    req_red = 1'b1;
    @(negedge clk);
    req_red = 1'b0;
    check_bit("single_grant_red", grant_red, 1'b1);
    check_bit("single_busy", busy, 1'b1);
    wait_done("single");
    repeat (3) @(negedge clk);
    check_bit("single_idle_after", busy, 1'b0);

    // Tie after reset: red, green, red, green
    do_reset();
    exp_q.push_back({1'b0, 1'b1, 8'd100, 8'd0});
    exp_q.push_back({1'b0, 1'b0, 8'd100, 8'd1});
    exp_q.push_back({1'b0, 1'b1, 8'd100, 8'd1});
    exp_q.push_back({1'b0, 1'b0, 8'd100, 8'd1});
    req_red = 1'b1;
    req_green = 1'b1;
    @(negedge clk);
    check_bit("tie_first_red", grant_red, 1'b1);
    for (int t = 0; t < 3; t++) wait_done("tie");
    @(negedge clk);
    check_bit("tie_fourth_green", grant_green, 1'b1);
    req_red = 1'b0;
    req_green = 1'b0;
    wait_done("tie_last");
    repeat (3) @(negedge clk);
    check_bit("tie_idle_after", busy, 1'b0);

    // Green request dropped 3 cycles after grant
    exp_q.push_back({1'b0, 1'b0, 8'd100, 8'd0});
    req_green = 1'b1;
    @(negedge clk);
    check_bit("drop_grant_green", grant_green, 1'b1);
    repeat (3) @(negedge clk);
    req_green = 1'b0;
    wait_done("drop");

    // Reset at busy cycle 40, then a green request
    repeat (2) @(negedge clk);
    exp_q.push_back({1'b1, 1'b1, 8'd40, 8'd0});
    req_red = 1'b1;
    @(negedge clk);
    req_red = 1'b0;
    check_bit("midrst_grant_red", grant_red, 1'b1);
    repeat (39) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (led_red != 0 || led_green != 0 || grant_red || grant_green || busy || done) begin
      failures++;
      $display("FAIL midrst_async: outputs nonzero right after rst, required all 0");
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'd100, 8'd0});
    req_green = 1'b1;
    @(negedge clk);
    req_green = 1'b0;
    check_bit("midrst_grant_green", grant_green, 1'b1);
    wait_done("midrst");
    repeat (3) @(negedge clk);

    tests++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
